// File: rtl/cacheline_adaptor.sv
// Converts one 256-bit cache-line read/write into a 4-beat 64-bit memory burst
// and pulses a single completion response back to the arbiter.
module cacheline_adaptor #(
   parameter int unsigned LINE_WIDTH  = 256,
   parameter int unsigned BURST_WIDTH = 64
) (
   input  logic                   clk,
   input  logic                   rst,
   // arbiter side
   input  logic [31:0]            address_i,
   input  logic [LINE_WIDTH-1:0]  line_i,
   output logic [LINE_WIDTH-1:0]  line_o,
   input  logic                   read_i,
   input  logic                   write_i,
   output logic                   resp_o,
   // memory side
   output logic [31:0]            address_o,
   input  logic [BURST_WIDTH-1:0] burst_i,
   output logic [BURST_WIDTH-1:0] burst_o,
   output logic                   read_o,
   output logic                   write_o,
   input  logic                   resp_i
);

   localparam int unsigned BEATS    = LINE_WIDTH / BURST_WIDTH;
   localparam logic [1:0]  LastBeat = 2'(BEATS - 1);

   typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

   state_e                  state;
   logic [1:0]              cnt;
   logic [1:0]              cnt_nxt;
   logic [LINE_WIDTH-1:0]   wbuf;

   assign cnt_nxt = cnt + 2'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= StIdle;
         cnt       <= 2'd0;
         resp_o    <= 1'b0;
         read_o    <= 1'b0;
         write_o   <= 1'b0;
         address_o <= '0;
         burst_o   <= '0;
         line_o    <= '0;
         wbuf      <= '0;
      end else begin
         resp_o <= 1'b0;
         unique case (state)
            StIdle: begin
               if (write_i || read_i) begin
                  address_o <= address_i & ~32'h0000_001F;
                  cnt       <= 2'd0;
                  // Write wins when both requests are raised.
                  if (write_i) begin
                     wbuf    <= line_i;
                     burst_o <= line_i[BURST_WIDTH-1:0];
                     write_o <= 1'b1;
                     state   <= StWrite;
                  end else begin
                     read_o <= 1'b1;
                     state  <= StRead;
                  end
               end
            end
            StRead: begin
               if (resp_i) begin
                  line_o[BURST_WIDTH*cnt +: BURST_WIDTH] <= burst_i;
                  cnt <= cnt_nxt;
                  if (cnt == LastBeat) begin
                     read_o <= 1'b0;
                     resp_o <= 1'b1;
                     state  <= StDone;
                  end
               end
            end
            StWrite: begin
               if (resp_i) begin
                  cnt <= cnt_nxt;
                  if (cnt == LastBeat) begin
                     write_o <= 1'b0;
                     resp_o  <= 1'b1;
                     state   <= StDone;
                  end else begin
                     // Present the next beat; it stays put until its strobe arrives.
                     burst_o <= wbuf[BURST_WIDTH*cnt_nxt +: BURST_WIDTH];
                  end
               end
            end
            StDone: begin
               state <= StIdle;
            end
            default: begin
               state <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: a vector table of line transactions plus
// hand-written sequences for back-to-back, mid-read reset and stray strobes.
module tb_cacheline_adaptor;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  address_i;
   logic [255:0] line_i;
   logic [255:0] line_o;
   logic         read_i;
   logic         write_i;
   logic         resp_o;
   logic [31:0]  address_o;
   logic [63:0]  burst_i;
   logic [63:0]  burst_o;
   logic         read_o;
   logic         write_o;
   logic         resp_i;

   int checks   = 0;
   int failures = 0;

   localparam logic [63:0] Junk = 64'hDEAD_BEEF_0BAD_F00D;

   typedef struct {
      logic             is_wr;
      logic             both;
      logic [31:0]      addr;
      logic [255:0]     line;
      logic [3:0][63:0] beat;      // read data returned, or expected write beats
      int               gap;
      logic [31:0]      exp_addr;
      logic [255:0]     exp_line;
   } vec_t;

   vec_t vecs [4];

   cacheline_adaptor dut (
      .clk       (clk),
      .rst       (rst),
      .address_i (address_i),
      .line_i    (line_i),
      .line_o    (line_o),
      .read_i    (read_i),
      .write_i   (write_i),
      .resp_o    (resp_o),
      .address_o (address_o),
      .burst_i   (burst_i),
      .burst_o   (burst_o),
      .read_o    (read_o),
      .write_o   (write_o),
      .resp_i    (resp_i)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [3:0][63:0] beats, input int gap,
                          input logic [31:0] exp_addr, input logic [255:0] exp_line,
                          input bit hold);
      int hi;
      read_i    = 1'b1;
      write_i   = 1'b0;
      address_i = addr;
      tick();
      chk("rd_accept_read_o", read_o, 1);
      chk("rd_accept_write_o", write_o, 0);
      chk("rd_address_o", address_o, exp_addr);
      hi = 1;
      for (int k = 0; k < 4; k++) begin
         for (int g = 0; g < gap; g++) begin
            tick();
            chk("rd_wait_resp_o", resp_o, 0);
            if (read_o) hi++;
         end
         resp_i  = 1'b1;
         burst_i = beats[k];
         tick();
         resp_i  = 1'b0;
         burst_i = Junk;
         if (k < 3) begin
            chk("rd_beat_resp_o", resp_o, 0);
            if (read_o) hi++;
         end
      end
      chk("rd_resp_o", resp_o, 1);
      chk("rd_done_read_o", read_o, 0);
      chk("rd_line_o", line_o, exp_line);
      chk("rd_read_o_cycles", hi, 4 + 4 * gap);
      if (!hold) read_i = 1'b0;
      tick();
      chk("rd_resp_single", resp_o, 0);
      chk("rd_idle_read_o", read_o, 0);
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                           input logic [3:0][63:0] beats, input int gap,
                           input logic [31:0] exp_addr, input logic both);
      write_i   = 1'b1;
      read_i    = both;
      address_i = addr;
      line_i    = line;
      if (both) $display("NOTE: protocol error, read_i and write_i both high");
      tick();
      line_i = '0;
      chk("wr_accept_write_o", write_o, 1);
      chk("wr_accept_read_o", read_o, 0);
      chk("wr_address_o", address_o, exp_addr);
      chk("wr_burst0", burst_o, beats[0]);
      for (int k = 0; k < 4; k++) begin
         for (int g = 0; g < gap; g++) begin
            tick();
            chk("wr_wait_burst_o", burst_o, beats[k]);
            chk("wr_wait_write_o", write_o, 1);
            chk("wr_wait_resp_o", resp_o, 0);
         end
         resp_i = 1'b1;
         tick();
         resp_i = 1'b0;
         if (k < 3) begin
            chk("wr_next_burst_o", burst_o, beats[k+1]);
            chk("wr_next_write_o", write_o, 1);
            chk("wr_next_read_o", read_o, 0);
         end
      end
      chk("wr_resp_o", resp_o, 1);
      chk("wr_done_write_o", write_o, 0);
      write_i = 1'b0;
      read_i  = 1'b0;
      tick();
      chk("wr_resp_single", resp_o, 0);
      chk("wr_idle_write_o", write_o, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{is_wr: 1'b0, both: 1'b0, addr: 32'h0000_104C, line: '0,
                  beat: {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                  gap: 0, exp_addr: 32'h0000_1040,
                  exp_line: 256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111};
      vecs[1] = '{is_wr: 1'b1, both: 1'b0, addr: 32'h2000_003F,
                  line: 256'hDDDDDDDDDDDDDDDD_CCCCCCCCCCCCCCCC_BBBBBBBBBBBBBBBB_AAAAAAAAAAAAAAAA,
                  beat: {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                         64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA},
                  gap: 2, exp_addr: 32'h2000_0020, exp_line: '0};
      vecs[2] = '{is_wr: 1'b0, both: 1'b0, addr: 32'hFFFF_FFFF, line: '0,
                  beat: {64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000,
                         64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF},
                  gap: 1, exp_addr: 32'hFFFF_FFE0,
                  exp_line: 256'hFFFFFFFFFFFFFFFF_0000000000000000_FEDCBA9876543210_0123456789ABCDEF};
      vecs[3] = '{is_wr: 1'b1, both: 1'b1, addr: 32'h0000_0080,
                  line: 256'h5555555555555555_6666666666666666_7777777777777777_8888888888888888,
                  beat: {64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                         64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888},
                  gap: 0, exp_addr: 32'h0000_0080, exp_line: '0};

      rst       = 1'b1;
      address_i = '0;
      line_i    = '0;
      read_i    = 1'b0;
      write_i   = 1'b0;
      burst_i   = Junk;
      resp_i    = 1'b0;
      tick();
      tick();
      chk("rst_resp_o", resp_o, 0);
      chk("rst_read_o", read_o, 0);
      chk("rst_write_o", write_o, 0);
      chk("rst_address_o", address_o, 0);
      chk("rst_burst_o", burst_o, 0);
      chk("rst_line_o", line_o, 0);
      rst = 1'b0;
      tick();

      for (int i = 0; i < 4; i++) begin
         if (vecs[i].is_wr)
            do_write(vecs[i].addr, vecs[i].line, vecs[i].beat, vecs[i].gap, vecs[i].exp_addr,
                     vecs[i].both);
         else
            do_read(vecs[i].addr, vecs[i].beat, vecs[i].gap, vecs[i].exp_addr,
                    vecs[i].exp_line, 1'b0);
      end

      // Back-to-back: read_i held through DONE, second read accepted only from IDLE.
      do_read(vecs[0].addr, vecs[0].beat, 0, vecs[0].exp_addr, vecs[0].exp_line, 1'b1);
      do_read(vecs[2].addr, vecs[2].beat, 0, vecs[2].exp_addr, vecs[2].exp_line, 1'b0);

      // Reset after two beats of a read.
      read_i    = 1'b1;
      address_i = 32'h3000_0010;
      tick();
      chk("mid_accept_read_o", read_o, 1);
      for (int k = 0; k < 2; k++) begin
         resp_i  = 1'b1;
         burst_i = 64'h9999_9999_9999_9999;
         tick();
      end
      resp_i  = 1'b0;
      burst_i = Junk;
      rst     = 1'b1;
      read_i  = 1'b0;
      tick();
      chk("mid_rst_read_o", read_o, 0);
      chk("mid_rst_resp_o", resp_o, 0);
      chk("mid_rst_line_o", line_o, 0);
      chk("mid_rst_address_o", address_o, 0);
      rst = 1'b0;
      tick();
      chk("mid_post_resp_o", resp_o, 0);
      do_read(32'h0000_5555, vecs[0].beat, 0, 32'h0000_5540, vecs[0].exp_line, 1'b0);

      // Stray strobes in IDLE must change nothing.
      resp_i  = 1'b1;
      burst_i = Junk;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("spur_line_o", line_o, vecs[0].exp_line);
         chk("spur_address_o", address_o, 32'h0000_5540);
         chk("spur_read_o", read_o, 0);
         chk("spur_write_o", write_o, 0);
         chk("spur_resp_o", resp_o, 0);
      end
      resp_i = 1'b0;
      tick();
      do_read(vecs[2].addr, vecs[2].beat, 0, vecs[2].exp_addr, vecs[2].exp_line, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
